mprj_io_serial_loader: RTL and testbench



---
 rtl/mprj_io_serial_loader.sv | 139 +++++++++++++
 tb/tb_mprj_io_serial_loader.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mprj_io_serial_loader.sv
// Shifts per-pad configuration images into the two user-I/O configuration chains,
// then pulses loader_load so the pads latch the shifted bits.
module mprj_io_serial_loader #(
    parameter int NUM_IO   = 19,
    parameter int CFG_BITS = 13,
    parameter int CLK_DIV  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NUM_IO*CFG_BITS-1:0]   cfg_data_1,
    input  logic [NUM_IO*CFG_BITS-1:0]   cfg_data_2,
    output logic                         busy,
    output logic                         done,
    output logic                         loader_resetn,
    output logic                         loader_clock,
    output logic                         loader_data_1,
    output logic                         loader_data_2,
    output logic                         loader_load
);

    localparam int N  = NUM_IO * CFG_BITS;
    localparam int PW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(N + 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(N - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        LOW  = 3'd2,
        HIGH = 3'd3,
        LOAD = 3'd4,
        FIN  = 3'd5
    } state_t;

    state_t         state;
    logic [PW-1:0]  phase_cnt;
    logic [BW-1:0]  bit_cnt;
    logic [N-1:0]   shadow_1;
    logic [N-1:0]   shadow_2;
    logic           phase_end;

    assign phase_end = (phase_cnt == PHASE_LAST);

    // All outputs are registered: each transition sets the outputs of the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            phase_cnt     <= '0;
            bit_cnt       <= '0;
            shadow_1      <= '0;
            shadow_2      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            loader_resetn <= 1'b1;
            loader_clock  <= 1'b0;
            loader_data_1 <= 1'b0;
            loader_data_2 <= 1'b0;
            loader_load   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shadow_1      <= cfg_data_1;
                        shadow_2      <= cfg_data_2;
                        state         <= CLR;
                        busy          <= 1'b1;
                        loader_resetn <= 1'b0;
                        phase_cnt     <= '0;
                        bit_cnt       <= '0;
                    end
                end
                CLR: begin
                    if (phase_end) begin
                        state         <= LOW;
                        phase_cnt     <= '0;
                        loader_resetn <= 1'b1;
                        loader_data_1 <= shadow_1[N-1];
                        loader_data_2 <= shadow_2[N-1];
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                LOW: begin
                    if (phase_end) begin
                        state        <= HIGH;
                        phase_cnt    <= '0;
                        loader_clock <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        phase_cnt    <= '0;
                        loader_clock <= 1'b0;
                        shadow_1     <= {shadow_1[N-2:0], 1'b0};
                        shadow_2     <= {shadow_2[N-2:0], 1'b0};
                        if (bit_cnt == BIT_LAST) begin
                            state         <= LOAD;
                            bit_cnt       <= '0;
                            loader_load   <= 1'b1;
                            loader_data_1 <= 1'b0;
                            loader_data_2 <= 1'b0;
                        end else begin
                            // The next LOW presents the bit that becomes the MSB after this shift.
                            state         <= LOW;
                            bit_cnt       <= bit_cnt + 1'b1;
                            loader_data_1 <= shadow_1[N-2];
                            loader_data_2 <= shadow_2[N-2];
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                LOAD: begin
                    if (phase_end) begin
                        state       <= FIN;
                        phase_cnt   <= '0;
                        loader_load <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mprj_io_serial_loader.sv
// Bench for mprj_io_serial_loader: three instances (small, divided, full size) each watched
// by a chain model that shifts on loader_clock rises and is compared on loader_load.
module tb_mprj_io_serial_loader;

    localparam int SN = 6;
    localparam int FN = 247;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [255:0] m1;
        logic [255:0] m2;
        logic [31:0]  busy_cnt;
        logic [31:0]  last_busy;
        logic [31:0]  rises;
        logic [31:0]  hi_cnt;
        logic [31:0]  lo_cnt;
        logic [31:0]  rst_cnt;
        logic [31:0]  ld_cnt;
        logic [31:0]  done_cnt;
        logic         pclk;
        logic         pd1;
        logic         pd2;
        logic         pclr;
        logic         pld;
        logic         pbusy;
        logic         pdone;
        logic         ev_load;
        logic         ev_end;
    } mon_t;

    // small instance (s) and divided instance (d) share the 6-bit images
    logic          s_start = 1'b0, d_start = 1'b0, f_start = 1'b0;
    logic [SN-1:0] s_cfg1 = '0, s_cfg2 = '0;
    logic [FN-1:0] f_cfg1 = '0, f_cfg2 = '0;
    logic s_busy, s_done, s_rstn, s_lclk, s_d1, s_d2, s_ld;
    logic d_busy, d_done, d_rstn, d_lclk, d_d1, d_d2, d_ld;
    logic f_busy, f_done, f_rstn, f_lclk, f_d1, f_d2, f_ld;

    // record layout: {busy length, image 2, image 1}
    logic [543:0] s_exp_q[$];
    logic [543:0] d_exp_q[$];
    logic [543:0] f_exp_q[$];
    mon_t ms, md, mf;

    mprj_io_serial_loader #(.NUM_IO(2), .CFG_BITS(3), .CLK_DIV(1)) u_s (
        .clk(clk), .reset(reset), .start(s_start), .cfg_data_1(s_cfg1), .cfg_data_2(s_cfg2),
        .busy(s_busy), .done(s_done), .loader_resetn(s_rstn), .loader_clock(s_lclk),
        .loader_data_1(s_d1), .loader_data_2(s_d2), .loader_load(s_ld));

    mprj_io_serial_loader #(.NUM_IO(2), .CFG_BITS(3), .CLK_DIV(4)) u_d (
        .clk(clk), .reset(reset), .start(d_start), .cfg_data_1(s_cfg1), .cfg_data_2(s_cfg2),
        .busy(d_busy), .done(d_done), .loader_resetn(d_rstn), .loader_clock(d_lclk),
        .loader_data_1(d_d1), .loader_data_2(d_d2), .loader_load(d_ld));

    mprj_io_serial_loader #(.NUM_IO(19), .CFG_BITS(13), .CLK_DIV(1)) u_f (
        .clk(clk), .reset(reset), .start(f_start), .cfg_data_1(f_cfg1), .cfg_data_2(f_cfg2),
        .busy(f_busy), .done(f_done), .loader_resetn(f_rstn), .loader_clock(f_lclk),
        .loader_data_1(f_d1), .loader_data_2(f_d2), .loader_load(f_ld));

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One negedge sample of an instance: protocol checks plus the chain model.
    task automatic mon_step(input string nm, input int n, input int div,
                            input logic busy, input logic done, input logic rstn,
                            input logic lclk, input logic d1, input logic d2, input logic ld,
                            inout mon_t st);
        mon_t s;
        logic [255:0] mask;
        logic changed;
        s = st;
        s.ev_load = 1'b0;
        s.ev_end  = 1'b0;
        mask = (256'd1 << n) - 256'd1;
        check({nm, "_clk_load_excl"}, 256'(lclk & ld), '0);
        check({nm, "_resetn_only_busy"}, 256'(!rstn && !busy), '0);
        check({nm, "_done_at_busy_end"}, 256'(done), 256'(!busy && s.pbusy));
        if (!busy) check({nm, "_idle_quiet"}, 256'({lclk, ld, d1, d2}), '0);
        if (busy) s.busy_cnt++;
        if (!rstn) begin
            s.rst_cnt++;
            s.m1 = '0;
            s.m2 = '0;
        end
        if (rstn && s.pclr) begin
            check({nm, "_clr_len"}, 256'(s.rst_cnt), 256'(div));
            s.rst_cnt = '0;
        end
        changed = (d1 != s.pd1) || (d2 != s.pd2);
        if (busy) check({nm, "_data_stable"}, 256'(changed && !((!lclk && s.pclk) || s.pclr)), '0);
        if (lclk && !s.pclk) begin
            check({nm, "_low_len"}, 256'(s.lo_cnt), 256'(div));
            s.lo_cnt = '0;
            s.m1 = ((s.m1 << 1) | 256'(d1)) & mask;
            s.m2 = ((s.m2 << 1) | 256'(d2)) & mask;
            s.rises++;
        end
        if (lclk) s.hi_cnt++;
        if (!lclk && s.pclk) begin
            check({nm, "_high_len"}, 256'(s.hi_cnt), 256'(div));
            s.hi_cnt = '0;
        end
        if (busy && rstn && !lclk && !ld) s.lo_cnt++;
        if (ld) s.ld_cnt++;
        if (ld && !s.pld) begin
            s.ev_load = 1'b1;
            check({nm, "_rise_count"}, 256'(s.rises), 256'(n));
            s.rises = '0;
        end
        if (!ld && s.pld) begin
            check({nm, "_load_len"}, 256'(s.ld_cnt), 256'(div));
            s.ld_cnt = '0;
        end
        if (done) begin
            check({nm, "_done_after_load"}, 256'(s.pld), 256'd1);
            check({nm, "_done_single"}, 256'(s.pdone), '0);
            s.done_cnt++;
        end
        if (!busy && s.pbusy) begin
            s.ev_end    = 1'b1;
            s.last_busy = s.busy_cnt;
            s.busy_cnt  = '0;
        end
        s.pclk  = lclk;
        s.pd1   = d1;
        s.pd2   = d2;
        s.pclr  = !rstn;
        s.pld   = ld;
        s.pbusy = busy;
        s.pdone = done;
        st = s;
    endtask

    always @(negedge clk) begin
        logic [543:0] rec;
        if (reset) begin
            ms = '0;
            s_exp_q.delete();
        end else begin
            mon_step("s", SN, 1, s_busy, s_done, s_rstn, s_lclk, s_d1, s_d2, s_ld, ms);
            if (ms.ev_load) begin
                if (s_exp_q.size() == 0) check("s_unexpected_load", 256'd1, '0);
                else begin
                    check("s_img1", ms.m1, s_exp_q[0][255:0]);
                    check("s_img2", ms.m2, s_exp_q[0][511:256]);
                end
            end
            if (ms.ev_end) begin
                if (s_exp_q.size() == 0) check("s_unexpected_end", 256'd1, '0);
                else begin
                    rec = s_exp_q.pop_front();
                    check("s_busy_len", 256'(ms.last_busy), 256'(rec[543:512]));
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [543:0] rec;
        if (reset) begin
            md = '0;
            d_exp_q.delete();
        end else begin
            mon_step("d", SN, 4, d_busy, d_done, d_rstn, d_lclk, d_d1, d_d2, d_ld, md);
            if (md.ev_load) begin
                if (d_exp_q.size() == 0) check("d_unexpected_load", 256'd1, '0);
                else begin
                    check("d_img1", md.m1, d_exp_q[0][255:0]);
                    check("d_img2", md.m2, d_exp_q[0][511:256]);
                end
            end
            if (md.ev_end) begin
                if (d_exp_q.size() == 0) check("d_unexpected_end", 256'd1, '0);
                else begin
                    rec = d_exp_q.pop_front();
                    check("d_busy_len", 256'(md.last_busy), 256'(rec[543:512]));
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [543:0] rec;
        if (reset) begin
            mf = '0;
            f_exp_q.delete();
        end else begin
            mon_step("f", FN, 1, f_busy, f_done, f_rstn, f_lclk, f_d1, f_d2, f_ld, mf);
            if (mf.ev_load) begin
                if (f_exp_q.size() == 0) check("f_unexpected_load", 256'd1, '0);
                else begin
                    check("f_img1", mf.m1, f_exp_q[0][255:0]);
                    check("f_img2", mf.m2, f_exp_q[0][511:256]);
                end
            end
            if (mf.ev_end) begin
                if (f_exp_q.size() == 0) check("f_unexpected_end", 256'd1, '0);
                else begin
                    rec = f_exp_q.pop_front();
                    check("f_busy_len", 256'(mf.last_busy), 256'(rec[543:512]));
                end
            end
        end
    end

    task automatic check_reset_s(input string tag);
        check({tag, "_busy"},   256'(s_busy), '0);
        check({tag, "_done"},   256'(s_done), '0);
        check({tag, "_resetn"}, 256'(s_rstn), 256'd1);
        check({tag, "_clock"},  256'(s_lclk), '0);
        check({tag, "_data1"},  256'(s_d1),   '0);
        check({tag, "_data2"},  256'(s_d2),   '0);
        check({tag, "_load"},   256'(s_ld),   '0);
    endtask

    task automatic run_s(input logic [SN-1:0] c1, input logic [SN-1:0] c2);
        s_cfg1 = c1;
        s_cfg2 = c2;
        s_exp_q.push_back({32'd14, 256'(c2), 256'(c1)});
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
    endtask

    task automatic run_f();
        logic [255:0] r1, r2;
        for (int i = 0; i < 8; i++) begin
            r1[i*32 +: 32] = $urandom;
            r2[i*32 +: 32] = $urandom;
        end
        f_cfg1 = r1[FN-1:0];
        f_cfg2 = r2[FN-1:0];
        f_exp_q.push_back({32'd496, 256'(f_cfg2), 256'(f_cfg1)});
        f_start = 1'b1;
        tick();
        f_start = 1'b0;
    endtask

    initial begin
        int rises;
        logic prev_clk;
        logic found;

        // reset values
        reset = 1'b1;
        repeat (3) tick();
        check_reset_s("rst");
        check("rst_d_busy", 256'(d_busy), '0);
        check("rst_f_busy", 256'(f_busy), '0);
        reset = 1'b0;
        tick();

        // basic load
        run_s(6'b101011, 6'b010100);
        check("basic_busy_rise", 256'(s_busy), 256'd1);
        check("basic_resetn_low", 256'(s_rstn), '0);
        repeat (20) tick();
        check("basic_done_count", 256'(ms.done_cnt), 256'd1);

        // divider
        d_exp_q.push_back({32'd56, 256'(6'b010100), 256'(6'b101011)});
        d_start = 1'b1;
        tick();
        d_start = 1'b0;
        repeat (70) tick();
        check("div_done_count", 256'(md.done_cnt), 256'd1);

        // input isolation and ignored start while busy
        run_s(6'b110010, 6'b001101);
        repeat (4) tick();
        s_cfg1 = '0;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        repeat (20) tick();
        check("iso_done_count", 256'(ms.done_cnt), 256'd2);
        check("iso_queue_empty", 256'(s_exp_q.size()), '0);
        check("iso_idle_busy", 256'(s_busy), '0);

        // reset during the third HIGH phase
        run_s(6'b011101, 6'b100110);
        rises = 0;
        prev_clk = s_lclk;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (s_lclk && !prev_clk) rises++;
            prev_clk = s_lclk;
            if (rises == 3) found = 1'b1;
            else tick();
        end
        check("midrst_reach_high3", 256'(found), 256'd1);
        reset = 1'b1;
        tick();
        check_reset_s("midrst");
        reset = 1'b0;
        tick();
        run_s(6'b100001, 6'b011110);
        repeat (20) tick();
        check("midrst_done_count", 256'(ms.done_cnt), 256'd1);

        // full default size, random images
        for (int k = 0; k < 2; k++) begin
            run_f();
            repeat (510) tick();
        end
        check("full_done_count", 256'(mf.done_cnt), 256'd2);

        check("end_s_queue", 256'(s_exp_q.size()), '0);
        check("end_d_queue", 256'(d_exp_q.size()), '0);
        check("end_f_queue", 256'(f_exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
